// File: rtl/ysyx_25030085_ifu_if.sv
// Fetch-unit bundle: PC-stage inputs, instruction-memory request/response
// channel and the decode-side instruction handshake.
interface ysyx_25030085_ifu_if #(
   parameter int XLEN = 32
);
   logic            fetch_en;
   logic [XLEN-1:0] pc_in;
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [XLEN-1:0] mem_req_addr;
   logic            mem_rsp_valid;
   logic [XLEN-1:0] mem_rsp_data;
   logic            mem_rsp_err;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst;
   logic [XLEN-1:0] inst_pc;
   logic            inst_fault;
   logic            pc_advance;
   logic            busy;

   modport master (
      input  fetch_en, pc_in, mem_req_ready, mem_rsp_valid, mem_rsp_data,
             mem_rsp_err, inst_ready,
      output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
             inst_fault, pc_advance, busy
   );

   modport slave (
      output fetch_en, pc_in, mem_req_ready, mem_rsp_valid, mem_rsp_data,
             mem_rsp_err, inst_ready,
      input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
             inst_fault, pc_advance, busy
   );
endinterface

// File: rtl/ysyx_25030085_ifu.sv
// Instruction fetch unit: one outstanding single-beat read, result held for decode.
// Optional performance counters enabled by defining IFU_PERF_CNT_EN.
module ysyx_25030085_ifu #(
   parameter int              XLEN           = 32,
   parameter logic [XLEN-1:0] NOP_INST       = 'h0000_0013,
   parameter int              TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ysyx_25030085_ifu_if.master   bus
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]           perf_fetch_cnt,
   output logic [31:0]           perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_e;

   localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

   state_e          state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic            fault_q, fault_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            timeout;

   // cnt_q counts completed WAIT cycles, so this fires on the last allowed one
   assign timeout = (cnt_q + 16'd1) == TMO;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         inst_q  <= '0;
         fault_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         inst_q  <= inst_d;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      inst_d  = inst_q;
      fault_d = fault_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.fetch_en) begin
               addr_d = bus.pc_in;
               if (bus.pc_in[1:0] != 2'b00) begin
                  state_d = S_HOLD;
                  inst_d  = NOP_INST;
                  fault_d = 1'b1;
               end else begin
                  state_d = S_REQ;
                  fault_d = 1'b0;
               end
            end
         end
         S_REQ: begin
            if (bus.mem_req_ready) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 16'd1;
            // A response in the timeout cycle still delivers its data
            if (bus.mem_rsp_valid) begin
               state_d = S_HOLD;
               inst_d  = bus.mem_rsp_err ? NOP_INST : bus.mem_rsp_data;
               fault_d = bus.mem_rsp_err;
            end else if (timeout) begin
               state_d = S_HOLD;
               inst_d  = NOP_INST;
               fault_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (bus.inst_ready) begin
               state_d = S_IDLE;
               fault_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.mem_req_valid = (state_q == S_REQ);
   assign bus.mem_req_addr  = addr_q;
   assign bus.inst_valid    = (state_q == S_HOLD);
   assign bus.inst          = inst_q;
   assign bus.inst_pc       = addr_q;
   assign bus.inst_fault    = fault_q;
   assign bus.pc_advance    = (state_q == S_HOLD) && bus.inst_ready;
   assign bus.busy          = (state_q != S_IDLE);

`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, stall_cnt_q;
   logic        stall;

   assign stall = ((state_q == S_REQ)  && !bus.mem_req_ready) ||
                  ((state_q == S_WAIT) && !bus.mem_rsp_valid) ||
                  ((state_q == S_HOLD) && !bus.inst_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (bus.pc_advance) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (stall)          stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_25030085_ifu.sv
// Bench for ysyx_25030085_ifu: directed fetches against a memory responder,
// with a transaction-level model checked every cycle at the falling edge.
`timescale 1ns/1ps
module tb_ysyx_25030085_ifu;
   localparam int          XLEN = 32;
   localparam int          TMO  = 20;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ysyx_25030085_ifu_if #(.XLEN(XLEN)) bus ();
`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

   ysyx_25030085_ifu #(.XLEN(XLEN), .NOP_INST(NOP), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetch_cnt(perf_fetch_cnt),
      .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   int tests = 0;
   int fails = 0;

   // Current transaction description shared by stimulus, responder and model
   logic [31:0] cfg_pc = '0;
   logic [31:0] cfg_data = '0;
   bit          cfg_err = 0;
   int          cfg_lat = 1;     // response delay after accept; 0 = never
   int          cfg_rdy = 0;     // cycles mem_req_ready is held low
   bit          cfg_late_rsp = 0;
   bit          exp_live = 0;    // a fetch is in flight, inst_valid is allowed
   int          adv_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Expected result of the current fetch, straight from the fault rules
   function automatic logic model_fault();
      if (cfg_pc[1:0] != 2'b00) return 1'b1;
      if (cfg_lat == 0 || cfg_lat > TMO) return 1'b1;
      return cfg_err;
   endfunction

   function automatic logic [31:0] model_inst();
      return model_fault() ? NOP : cfg_data;
   endfunction

   // Falling edges from accept to first inst_valid
   function automatic int model_latency();
      return (cfg_lat != 0 && cfg_lat <= TMO) ? cfg_lat + 1 : TMO + 1;
   endfunction

   // Memory responder: acts just after each rising edge
   initial begin
      bit rdy_drv, vld_seen, outstanding, rsp_drv;
      int req_wait, rsp_cnt;
      rdy_drv = 0; vld_seen = 0; outstanding = 0; rsp_drv = 0;
      req_wait = 0; rsp_cnt = 0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_err   = 1'b0;
      bus.mem_rsp_data  = '0;
      forever begin
         @(posedge clk); #1;
         if (rsp_drv) outstanding = 0;
         if (rdy_drv && vld_seen) begin outstanding = 1; rsp_cnt = 0; end
         rdy_drv = 0; rsp_drv = 0;
         bus.mem_req_ready = 1'b0;
         bus.mem_rsp_valid = 1'b0;
         bus.mem_rsp_err   = 1'b0;
         bus.mem_rsp_data  = '0;
         vld_seen = bus.mem_req_valid;
         if (!rst_n) begin
            outstanding = 0; req_wait = 0;
         end else begin
            if (bus.mem_req_valid) begin
               if (req_wait >= cfg_rdy) begin
                  bus.mem_req_ready = 1'b1; rdy_drv = 1; req_wait = 0;
               end else req_wait++;
            end
            if (outstanding) begin
               rsp_cnt++;
               if (cfg_lat != 0 && rsp_cnt >= cfg_lat) begin
                  bus.mem_rsp_valid = 1'b1;
                  bus.mem_rsp_data  = cfg_data;
                  bus.mem_rsp_err   = cfg_err;
                  rsp_drv = 1;
               end
            end else if (cfg_late_rsp) begin
               bus.mem_rsp_valid = 1'b1;
               bus.mem_rsp_data  = 32'hCAFE_F00D;
            end
         end
      end
   end

   // Per-cycle compare against the transaction model
   initial begin
      int cyc, accept_cyc, accepts, m_fetch, m_stall;
      bit prev_iv, waiting;
      cyc = 0; accept_cyc = 0; accepts = 0; m_fetch = 0; m_stall = 0;
      prev_iv = 0; waiting = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_iv = 0; waiting = 0; accepts = 0; m_fetch = 0; m_stall = 0;
            continue;
         end
`ifdef IFU_PERF_CNT_EN
         chk("perf_fetch_cnt", perf_fetch_cnt, 32'(m_fetch));
         chk("perf_stall_cnt", perf_stall_cnt, 32'(m_stall));
`endif
         if (bus.inst_valid) waiting = 0;
         chk("pc_advance", {31'd0, bus.pc_advance}, {31'd0, bus.inst_valid && bus.inst_ready});
         chk("busy", {31'd0, bus.busy}, {31'd0, bus.mem_req_valid || waiting || bus.inst_valid});
         if (bus.pc_advance) adv_total++;
         if (bus.mem_req_valid) begin
            chk("req_for_aligned_pc_only", {30'd0, cfg_pc[1:0]}, 32'd0);
            chk("mem_req_addr", bus.mem_req_addr, cfg_pc);
         end
         if (bus.inst_valid) begin
            chk("inst_valid_while_live", {31'd0, exp_live}, 32'd1);
            chk("inst", bus.inst, model_inst());
            chk("inst_pc", bus.inst_pc, cfg_pc);
            chk("inst_fault", {31'd0, bus.inst_fault}, {31'd0, model_fault()});
            if (!prev_iv) begin
               if (cfg_pc[1:0] == 2'b00) begin
                  chk("fetch_latency", 32'(cyc - accept_cyc), 32'(model_latency()));
                  chk("accepts_per_fetch", 32'(accepts), 32'd1);
               end else begin
                  chk("accepts_misaligned", 32'(accepts), 32'd0);
               end
            end
         end
         if ((bus.mem_req_valid && !bus.mem_req_ready) ||
             (waiting && !bus.mem_rsp_valid) ||
             (bus.inst_valid && !bus.inst_ready)) m_stall++;
         if (bus.inst_valid && bus.inst_ready) begin m_fetch++; accepts = 0; end
         if (bus.mem_req_valid && bus.mem_req_ready) begin
            accepts++; accept_cyc = cyc; waiting = 1;
         end
         prev_iv = bus.inst_valid;
      end
   end

   // Results of the last do_fetch call
   int          first_iv, n_hs, req_cycles;
   logic [31:0] got_addr, got_inst, got_pc;
   logic        got_fault;

   // Called just after a rising edge; returns just after the handoff edge
   task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data, input bit err,
                           input int lat, input int rdy, input int irdy, input bit keep_en);
      int n, held;
      bit hs, done;
      cfg_pc = pc; cfg_data = data; cfg_err = err; cfg_lat = lat; cfg_rdy = rdy;
      exp_live = 1;
      bus.pc_in = pc;
      bus.fetch_en = 1'b1;
      bus.inst_ready = 1'b0;
      n = 0; held = 0; hs = 0; done = 0;
      first_iv = -1; n_hs = -1; req_cycles = 0;
      got_addr = 'x; got_inst = 'x; got_pc = 'x; got_fault = 1'bx;
      while (!done) begin
         @(posedge clk); #1;
         n++;
         if (!keep_en) bus.fetch_en = 1'b0;
         if (hs) done = 1;
         else begin
            if (bus.mem_req_valid) begin
               if (req_cycles == 0) got_addr = bus.mem_req_addr;
               req_cycles++;
            end
            if (bus.inst_valid) begin
               if (first_iv < 0) begin
                  first_iv = n; got_inst = bus.inst; got_pc = bus.inst_pc; got_fault = bus.inst_fault;
               end
               if (held >= irdy) begin bus.inst_ready = 1'b1; hs = 1; n_hs = n; end
               held++;
            end
            if (n >= 300) begin
               tests++; fails++;
               $display("FAIL fetch_timeout: no handoff for pc %h after %0d cycles, required one", pc, n);
               done = 1;
            end
         end
      end
      bus.inst_ready = 1'b0;
      exp_live = 0;
   endtask

   initial begin
      int adv0;
      bus.fetch_en = 1'b0;
      bus.pc_in = '0;
      bus.inst_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
      chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
      chk("rst_inst_fault", {31'd0, bus.inst_fault}, 32'd0);
      chk("rst_pc_advance", {31'd0, bus.pc_advance}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_mem_req_addr", bus.mem_req_addr, 32'd0);
      chk("rst_inst", bus.inst, 32'd0);
      chk("rst_inst_pc", bus.inst_pc, 32'd0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic fetch with single-cycle memory
      adv0 = adv_total;
      do_fetch(32'h8000_0000, 32'h0000_0297, 0, 1, 0, 0, 0);
      chk("f1_req_addr", got_addr, 32'h8000_0000);
      chk("f1_inst", got_inst, 32'h0000_0297);
      chk("f1_inst_pc", got_pc, 32'h8000_0000);
      chk("f1_fault", {31'd0, got_fault}, 32'd0);
      chk("f1_advance_cycle", 32'(n_hs), 32'd3);
      chk("f1_advance_count", 32'(adv_total - adv0), 32'd1);

      // Request back-pressure for 5 cycles
      do_fetch(32'h8000_0004, 32'h0010_0093, 0, 1, 5, 0, 0);
      chk("f2_req_cycles", 32'(req_cycles), 32'd6);
      chk("f2_inst", got_inst, 32'h0010_0093);

      // Misaligned PC: no request, immediate fault
      do_fetch(32'h8000_0002, 32'h1111_1111, 0, 1, 0, 0, 0);
      chk("f3_req_cycles", 32'(req_cycles), 32'd0);
      chk("f3_inst", got_inst, 32'h0000_0013);
      chk("f3_fault", {31'd0, got_fault}, 32'd1);
      chk("f3_first_valid", 32'(first_iv), 32'd1);

      // Bus error
      do_fetch(32'h8000_0008, 32'hDEAD_BEEF, 1, 2, 0, 0, 0);
      chk("f4_inst", got_inst, 32'h0000_0013);
      chk("f4_fault", {31'd0, got_fault}, 32'd1);

      // No response: timeout after exactly TMO WAIT cycles
      do_fetch(32'h8000_0010, 32'h2222_2222, 0, 0, 0, 0, 0);
      chk("f5_inst", got_inst, 32'h0000_0013);
      chk("f5_fault", {31'd0, got_fault}, 32'd1);
      chk("f5_first_valid", 32'(first_iv), 32'(TMO + 2));

      // Response on the timeout cycle wins; one cycle later it loses
      do_fetch(32'h8000_0014, 32'h1234_5678, 0, TMO, 0, 0, 0);
      chk("f6_inst", got_inst, 32'h1234_5678);
      chk("f6_fault", {31'd0, got_fault}, 32'd0);
      chk("f6_first_valid", 32'(first_iv), 32'(TMO + 2));
      do_fetch(32'h8000_0018, 32'h8765_4321, 0, TMO + 1, 0, 0, 0);
      chk("f7_inst", got_inst, 32'h0000_0013);
      chk("f7_fault", {31'd0, got_fault}, 32'd1);

      // Decode back-pressure for 3 cycles
      adv0 = adv_total;
      do_fetch(32'h8000_001C, 32'h0000_0513, 0, 1, 0, 3, 0);
      chk("f8_advance_cycle", 32'(n_hs), 32'd6);
      chk("f8_advance_count", 32'(adv_total - adv0), 32'd1);

      // Reset while waiting for memory
      cfg_pc = 32'h8000_0020; cfg_data = 32'h3333_3333; cfg_err = 0; cfg_lat = 0; cfg_rdy = 0;
      exp_live = 1;
      bus.pc_in = 32'h8000_0020;
      bus.fetch_en = 1'b1;
      @(posedge clk); #1 bus.fetch_en = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("wait_busy", {31'd0, bus.busy}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_mem_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
      chk("arst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
      chk("arst_busy", {31'd0, bus.busy}, 32'd0);
      chk("arst_pc_advance", {31'd0, bus.pc_advance}, 32'd0);
      chk("arst_inst_fault", {31'd0, bus.inst_fault}, 32'd0);
      chk("arst_mem_req_addr", bus.mem_req_addr, 32'd0);
      chk("arst_inst", bus.inst, 32'd0);
      chk("arst_inst_pc", bus.inst_pc, 32'd0);
      exp_live = 0;
      @(posedge clk); #2 rst_n = 1'b1;
      cfg_late_rsp = 1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("late_rsp_ignored", {31'd0, bus.inst_valid}, 32'd0);
      end
      cfg_late_rsp = 0;

      // Three back-to-back fetches with two stall cycles
      adv0 = adv_total;
      do_fetch(32'h8000_0100, 32'h0000_0001, 0, 1, 0, 0, 1);
      do_fetch(32'h8000_0104, 32'h0000_0002, 0, 1, 1, 0, 1);
      do_fetch(32'h8000_0108, 32'h0000_0003, 0, 2, 0, 0, 1);
      bus.fetch_en = 1'b0;
      chk("b2b_inst", got_inst, 32'h0000_0003);
      chk("b2b_advance_count", 32'(adv_total - adv0), 32'd3);
`ifdef IFU_PERF_CNT_EN
      chk("perf_fetch_lit", perf_fetch_cnt, 32'd3);
      chk("perf_stall_lit", perf_stall_cnt, 32'd2);
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("idle_after_b2b", {31'd0, bus.busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1);
   end
endmodule
